// File: rtl/asrm_gpio_pkg.sv
// Shared definitions for the asrm GPIO peripheral: register block indices
// and the words-per-block helper.
package asrm_gpio_pkg;

    localparam int BLK_GPI     = 0;
    localparam int BLK_GPO     = 1;
    localparam int BLK_IRQ_EN  = 2;
    localparam int BLK_RISE_EN = 3;
    localparam int BLK_FALL_EN = 4;
    localparam int BLK_FLAG    = 5;
    localparam int NUM_BLOCKS  = 6;

    // Bus words needed to cover all pins of one register block.
    function automatic int num_words(input int gpio_width, input int wordsize);
        return (gpio_width + wordsize - 1) / wordsize;
    endfunction

endpackage

// File: rtl/asrm_gpio_edge.sv
// Input synchroniser, edge detection and sticky interrupt flags.
// Set has priority over a simultaneous write-1-to-clear.
module asrm_gpio_edge #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] gpi,
    input  logic [width-1:0] rise_en,
    input  logic [width-1:0] fall_en,
    input  logic [width-1:0] clear_mask,
    output logic [width-1:0] sync_val,
    output logic [width-1:0] flag
);

    logic [width-1:0] s1_reg;
    logic [width-1:0] s2_reg;
    logic [width-1:0] prev_reg;
    logic [width-1:0] flag_reg;
    logic [width-1:0] rise;
    logic [width-1:0] fall;

    assign rise = s2_reg & ~prev_reg & rise_en;
    assign fall = ~s2_reg & prev_reg & fall_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            prev_reg <= '0;
            flag_reg <= '0;
        end else begin
            s1_reg   <= gpi;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
            flag_reg <= (flag_reg & ~clear_mask) | rise | fall;
        end
    end

    assign sync_val = s2_reg;
    assign flag     = flag_reg;

endmodule

// File: rtl/asrm_gpio_irq.sv
// Memory-mapped GPIO with edge-triggered sticky interrupt flags.
// Six register blocks of N bus words each; read data is 0 when not hit.
module asrm_gpio_irq
    import asrm_gpio_pkg::*;
#(
    parameter int wordsize       = 8,
    parameter int base_addr_size = 7,
    parameter int base_addr      = 0,
    parameter int gpio_width     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [gpio_width-1:0]     gpi,
    output logic [gpio_width-1:0]     gpo,
    output logic                      irq
);

    localparam int N        = num_words(gpio_width, wordsize);
    localparam int PW       = N * wordsize;
    localparam int NUM_REGS = NUM_BLOCKS * N;

    // Extra MSB catches the borrow when addr is below base_addr.
    logic [base_addr_size:0] idx_ext;
    logic [31:0]             idx;
    logic                    hit;
    logic                    wr_hit;

    assign idx_ext = {1'b0, addr} - (base_addr_size + 1)'(base_addr);
    assign idx     = 32'(idx_ext[base_addr_size-1:0]);
    assign hit     = enable && !idx_ext[base_addr_size] && (idx < 32'(NUM_REGS));
    assign wr_hit  = hit && write_en;

    logic [gpio_width-1:0] wdata_pins;
    logic [gpio_width-1:0] gpo_sel;
    logic [gpio_width-1:0] irq_en_sel;
    logic [gpio_width-1:0] rise_en_sel;
    logic [gpio_width-1:0] fall_en_sel;
    logic [gpio_width-1:0] flag_sel;

    genvar gi;
    generate
        for (gi = 0; gi < gpio_width; gi++) begin : g_pin
            localparam int WORD = gi / wordsize;
            assign wdata_pins[gi]  = data_in[gi % wordsize];
            assign gpo_sel[gi]     = wr_hit && (idx == 32'(BLK_GPO     * N + WORD));
            assign irq_en_sel[gi]  = wr_hit && (idx == 32'(BLK_IRQ_EN  * N + WORD));
            assign rise_en_sel[gi] = wr_hit && (idx == 32'(BLK_RISE_EN * N + WORD));
            assign fall_en_sel[gi] = wr_hit && (idx == 32'(BLK_FALL_EN * N + WORD));
            assign flag_sel[gi]    = wr_hit && (idx == 32'(BLK_FLAG    * N + WORD));
        end
    endgenerate

    logic [gpio_width-1:0] gpo_reg;
    logic [gpio_width-1:0] irq_en_reg;
    logic [gpio_width-1:0] rise_en_reg;
    logic [gpio_width-1:0] fall_en_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpo_reg     <= '0;
            irq_en_reg  <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
        end else begin
            gpo_reg     <= (gpo_reg     & ~gpo_sel)     | (wdata_pins & gpo_sel);
            irq_en_reg  <= (irq_en_reg  & ~irq_en_sel)  | (wdata_pins & irq_en_sel);
            rise_en_reg <= (rise_en_reg & ~rise_en_sel) | (wdata_pins & rise_en_sel);
            fall_en_reg <= (fall_en_reg & ~fall_en_sel) | (wdata_pins & fall_en_sel);
        end
    end

    logic [gpio_width-1:0] sync_val;
    logic [gpio_width-1:0] flag;

    asrm_gpio_edge #(
        .width(gpio_width)
    ) u_edge (
        .clk       (clk),
        .reset     (reset),
        .gpi       (gpi),
        .rise_en   (rise_en_reg),
        .fall_en   (fall_en_reg),
        .clear_mask(wdata_pins & flag_sel),
        .sync_val  (sync_val),
        .flag      (flag)
    );

    assign gpo = gpo_reg;
    assign irq = |(flag & irq_en_reg);

    // Zero-padded view of every block so bits past gpio_width read as 0.
    logic [PW-1:0] blk [NUM_BLOCKS];

    always_comb begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            blk[b] = '0;
        end
        blk[BLK_GPI][gpio_width-1:0]     = sync_val;
        blk[BLK_GPO][gpio_width-1:0]     = gpo_reg;
        blk[BLK_IRQ_EN][gpio_width-1:0]  = irq_en_reg;
        blk[BLK_RISE_EN][gpio_width-1:0] = rise_en_reg;
        blk[BLK_FALL_EN][gpio_width-1:0] = fall_en_reg;
        blk[BLK_FLAG][gpio_width-1:0]    = flag;
    end

    always_comb begin
        data_out = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            for (int i = 0; i < N; i++) begin
                if (hit && (idx == 32'(b * N + i))) begin
                    data_out = blk[b][i*wordsize +: wordsize];
                end
            end
        end
    end

endmodule

// File: tb/tb_asrm_gpio_irq.sv
// Directed bench for asrm_gpio_irq (wordsize 8, 12 pins, N = 2).
module tb_asrm_gpio_irq;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [6:0]  addr;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [11:0] gpi;
    logic [11:0] gpo;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    asrm_gpio_irq #(
        .wordsize      (8),
        .base_addr_size(7),
        .base_addr     (0),
        .gpio_width    (12)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .gpi     (gpi),
        .gpo     (gpo),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [6:0]  addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic [11:0] exp_gpo;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        enable   = 1'b1;
        addr     = a;
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [6:0] a, input logic [7:0] exp);
        addr     = a;
        write_en = 1'b0;
        #1;
        chk(name, 32'(data_out), 32'(exp));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 7'd2,   1'b1, 8'hCD, 8'hCD, 12'h0CD};
        vecs[1]  = '{1'b1, 7'd3,   1'b1, 8'hFB, 8'h0B, 12'hBCD};
        vecs[2]  = '{1'b1, 7'd2,   1'b0, 8'h00, 8'hCD, 12'hBCD};
        vecs[3]  = '{1'b1, 7'd4,   1'b1, 8'h5A, 8'h5A, 12'hBCD};
        vecs[4]  = '{1'b1, 7'd5,   1'b1, 8'hFF, 8'h0F, 12'hBCD};
        vecs[5]  = '{1'b1, 7'd6,   1'b1, 8'h3C, 8'h3C, 12'hBCD};
        vecs[6]  = '{1'b1, 7'd9,   1'b1, 8'hF0, 8'h00, 12'hBCD};
        vecs[7]  = '{1'b1, 7'd0,   1'b1, 8'hFF, 8'h00, 12'hBCD};
        vecs[8]  = '{1'b0, 7'd2,   1'b1, 8'h00, 8'h00, 12'hBCD};
        vecs[9]  = '{1'b1, 7'd12,  1'b1, 8'h00, 8'h00, 12'hBCD};
        vecs[10] = '{1'b1, 7'd127, 1'b1, 8'h00, 8'h00, 12'hBCD};
        vecs[11] = '{1'b1, 7'd2,   1'b0, 8'h00, 8'hCD, 12'hBCD};
        vecs[12] = '{1'b1, 7'd11,  1'b1, 8'hFF, 8'h00, 12'hBCD};

        reset    = 1'b1;
        enable   = 1'b0;
        addr     = '0;
        write_en = 1'b0;
        data_in  = '0;
        gpi      = '0;
        tick();
        tick();
        chk("reset_gpo", 32'(gpo), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rd", 32'(data_out), 32'h0);
        reset = 1'b0;
        tick();

        // Register read/write, padding and decode boundaries
        for (int i = 0; i < 13; i++) begin
            enable   = vecs[i].en;
            addr     = vecs[i].addr;
            data_in  = vecs[i].wdata;
            write_en = vecs[i].we;
            tick();
            write_en = 1'b0;
            #1;
            chk($sformatf("vec%0d_rd", i), 32'(data_out), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_gpo", i), 32'(gpo), 32'(vecs[i].exp_gpo));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
        end

        for (int a = 4; a <= 9; a++) wr(7'(a), 8'h00);

        // Synchroniser latency: visible on 2nd edge, not the 1st
        gpi = 12'hABC;
        tick();
        rdchk("sync_e1_lo", 7'd0, 8'h00);
        rdchk("sync_e1_hi", 7'd1, 8'h00);
        tick();
        rdchk("sync_e2_lo", 7'd0, 8'hBC);
        rdchk("sync_e2_hi", 7'd1, 8'h0A);
        rdchk("no_flag_lo", 7'd10, 8'h00);
        gpi = 12'h000;
        tick(); tick(); tick();

        // Rising edge flag exactly 3 edges later
        wr(7'd6, 8'h01);
        wr(7'd4, 8'h01);
        gpi = 12'h001;
        tick();
        chk("rise_e1_irq", 32'(irq), 32'h0);
        tick();
        chk("rise_e2_irq", 32'(irq), 32'h0);
        rdchk("rise_e2_flag", 7'd10, 8'h00);
        tick();
        chk("rise_e3_irq", 32'(irq), 32'h1);
        rdchk("rise_e3_flag", 7'd10, 8'h01);
        gpi = 12'h000;
        tick(); tick(); tick(); tick();
        rdchk("fall_ignored_flag", 7'd10, 8'h01);
        chk("fall_ignored_irq", 32'(irq), 32'h1);

        // Write-1-to-clear
        wr(7'd10, 8'h01);
        chk("clr_irq", 32'(irq), 32'h0);
        rdchk("clr_flag", 7'd10, 8'h00);

        // Clear coinciding with new rising edge: set wins
        gpi = 12'h001;
        tick(); tick(); tick();
        rdchk("reset_up_flag", 7'd10, 8'h01);
        gpi = 12'h000;
        tick(); tick(); tick();
        gpi = 12'h001;
        tick(); tick();
        wr(7'd10, 8'h01);
        rdchk("clr_vs_set_flag", 7'd10, 8'h01);
        chk("clr_vs_set_irq", 32'(irq), 32'h1);
        wr(7'd10, 8'h01);
        rdchk("clr_again_flag", 7'd10, 8'h00);

        // Falling edge on pin 9 with irq masked, then unmask
        wr(7'd9, 8'h02);
        gpi = 12'h201;
        tick(); tick(); tick();
        rdchk("pin9_rise_noflag", 7'd11, 8'h00);
        gpi = 12'h001;
        tick(); tick(); tick();
        rdchk("pin9_fall_flag", 7'd11, 8'h02);
        chk("pin9_masked_irq", 32'(irq), 32'h0);
        wr(7'd5, 8'h02);
        chk("pin9_unmask_irq", 32'(irq), 32'h1);
        enable = 1'b0;
        #1;
        chk("disabled_rd", 32'(data_out), 32'h0);
        enable = 1'b1;

        // Asynchronous reset with flags pending
        reset = 1'b1;
        #2;
        chk("areset_gpo", 32'(gpo), 32'h0);
        chk("areset_irq", 32'(irq), 32'h0);
        rdchk("areset_flag", 7'd11, 8'h00);
        rdchk("areset_irqen", 7'd5, 8'h00);
        rdchk("areset_gpo_reg", 7'd3, 8'h00);
        enable = 1'b0;
        #1;
        chk("areset_rd_disabled", 32'(data_out), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
